// File: rtl/wb_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_stage_pkg
//  Description : Shared write-back stage types and constants. Provides the
//                write-value source select, the load funct3 codes and the
//                write-back FSM state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_stage_pkg;

  // Register-file write value source (i_ma_rw_sel encoding)
  typedef enum logic [1:0] {
    WB_MUX  = 2'b00,   // ALU result or load data, chosen by mem_to_reg
    WB_PC4  = 2'b01,   // PC+4 (JAL/JALR link)
    WB_IMM  = 2'b10,   // U-type immediate (LUI)
    WB_ZERO = 2'b11    // constant zero
  } wb_sel_e;

  // Load funct3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Write-back FSM states
  typedef enum logic [0:0] {
    RUN       = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_e;

endpackage : wb_stage_pkg
`default_nettype wire

// File: rtl/wb_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_stage_if
//  Description : Bundle of the MA-to-WB handshake, data-memory read return,
//                flush and the write-back / status outputs of wb_stage.
//  Ports       : slave  - wb_stage side (consumes i_*, drives o_*)
//                master - environment side (drives i_*, consumes o_*)
//  Revision    : 1.0 - initial release
// ============================================================================
interface wb_stage_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 64
);
  logic              i_ma_valid;
  logic              o_ma_ready;
  logic              i_ma_mem_to_reg;
  logic [1:0]        i_ma_rw_sel;
  logic [2:0]        i_ma_funct3;
  logic [REG_AW-1:0] i_ma_rd;
  logic              i_ma_reg_write;
  logic [XLEN-1:0]   i_ma_result;
  logic [XLEN-1:0]   i_ma_pc_plus_4;
  logic [XLEN-1:0]   i_ma_imm;
  logic [XLEN-1:0]   i_mem_rdata;
  logic              i_mem_rvalid;
  logic              i_flush;
  logic              o_wb_valid;
  logic              o_wb_we;
  logic [REG_AW-1:0] o_wb_rd;
  logic [XLEN-1:0]   o_wb_data;
  logic [CNT_W-1:0]  o_retire_cnt;
  logic [CNT_W-1:0]  o_stall_cnt;
  logic              o_busy;

  modport slave (
    input  i_ma_valid, i_ma_mem_to_reg, i_ma_rw_sel, i_ma_funct3, i_ma_rd,
           i_ma_reg_write, i_ma_result, i_ma_pc_plus_4, i_ma_imm,
           i_mem_rdata, i_mem_rvalid, i_flush,
    output o_ma_ready, o_wb_valid, o_wb_we, o_wb_rd, o_wb_data,
           o_retire_cnt, o_stall_cnt, o_busy
  );

  modport master (
    output i_ma_valid, i_ma_mem_to_reg, i_ma_rw_sel, i_ma_funct3, i_ma_rd,
           i_ma_reg_write, i_ma_result, i_ma_pc_plus_4, i_ma_imm,
           i_mem_rdata, i_mem_rvalid, i_flush,
    input  o_ma_ready, o_wb_valid, o_wb_we, o_wb_rd, o_wb_data,
           o_retire_cnt, o_stall_cnt, o_busy
  );
endinterface : wb_stage_if
`default_nettype wire

// File: rtl/wb_stage_load_extend.sv
`default_nettype none
// ============================================================================
//  Module      : wb_stage_load_extend
//  Description : Combinational load data extraction. Picks the addressed
//                byte/half from an aligned memory word and sign- or
//                zero-extends it; any other funct3 passes the full word.
//  Ports       : rdata_i  - aligned word from data memory
//                offset_i - byte offset within the word (off[0] ignored
//                           for halves)
//                funct3_i - load type
//                ext_o    - extended load value
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_stage_load_extend
  import wb_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      offset_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] ext_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Bit index = offset*8 for bytes, offset[1]*16 for halves
  assign w_byte = rdata_i[{offset_i, 3'b000} +: 8];
  assign w_half = rdata_i[{offset_i[1], 4'b0000} +: 16];

  always_comb begin
    ext_o = rdata_i;
    case (funct3_i)
      F3_LB:   ext_o = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_LBU:  ext_o = {{(XLEN-8){1'b0}}, w_byte};
      F3_LH:   ext_o = {{(XLEN-16){w_half[15]}}, w_half};
      F3_LHU:  ext_o = {{(XLEN-16){1'b0}}, w_half};
      default: ext_o = rdata_i;
    endcase
  end

endmodule : wb_stage_load_extend
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : wb_stage
//  Description : Registered RV32I write-back stage. Accepts one instruction
//                per cycle from MA, stalls MA while load data is outstanding,
//                selects the register-file write value, honours flush and
//                keeps retire / load-stall counters.
//  Ports       : i_clk - clock, rising edge
//                i_rst - synchronous active-high reset
//                bus   - wb_stage_if slave: MA handshake and operands,
//                        memory read return, flush, write-back outputs,
//                        counters and busy flag
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int XLEN   = 32,   // must match the connected interface
  parameter int REG_AW = 5,
  parameter int CNT_W  = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  wb_stage_if.slave   bus
);

  localparam logic [0:0] ST_RUN  = RUN;
  localparam logic [0:0] ST_WAIT = WAIT_LOAD;

  logic [0:0]        state_q, state_d;
  logic              wb_valid_q;
  logic              wb_we_q;
  logic [REG_AW-1:0] wb_rd_q;
  logic [XLEN-1:0]   wb_data_q;
  logic [CNT_W-1:0]  retire_cnt_q;
  logic [CNT_W-1:0]  stall_cnt_q;

  logic              w_load_pend;
  logic              w_ready;
  logic              w_accept;
  logic              w_stall;
  logic              w_we;
  logic [XLEN-1:0]   w_load_val;
  logic [XLEN-1:0]   w_data;

  // A load is outstanding when MA presents a mem-sourced mux write
  assign w_load_pend = bus.i_ma_valid && bus.i_ma_mem_to_reg &&
                       (bus.i_ma_rw_sel == WB_MUX);
  // Flush always lets the instruction through so it can be dropped
  assign w_ready  = bus.i_flush || !(w_load_pend && !bus.i_mem_rvalid);
  assign w_accept = bus.i_ma_valid && w_ready;
  assign w_stall  = bus.i_ma_valid && !w_ready;
  assign w_we     = bus.i_ma_reg_write && (bus.i_ma_rd != '0);

  wb_stage_load_extend #(
    .XLEN (XLEN)
  ) u_load_extend (
    .rdata_i  (bus.i_mem_rdata),
    .offset_i (bus.i_ma_result[1:0]),
    .funct3_i (bus.i_ma_funct3),
    .ext_o    (w_load_val)
  );

  always_comb begin
    w_data = '0;
    case (wb_sel_e'(bus.i_ma_rw_sel))
      WB_MUX:  w_data = bus.i_ma_mem_to_reg ? w_load_val : bus.i_ma_result;
      WB_PC4:  w_data = bus.i_ma_pc_plus_4;
      WB_IMM:  w_data = bus.i_ma_imm;
      default: w_data = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (w_load_pend && !bus.i_mem_rvalid && !bus.i_flush) state_d = ST_WAIT;
      ST_WAIT: if (bus.i_mem_rvalid || bus.i_flush) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_RUN;
      wb_valid_q   <= 1'b0;
      wb_we_q      <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      retire_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      // Counts the write-back presented this cycle (we=0 included)
      retire_cnt_q <= retire_cnt_q + {{(CNT_W-1){1'b0}}, wb_valid_q};
      stall_cnt_q  <= stall_cnt_q + {{(CNT_W-1){1'b0}}, w_stall};
      if (w_accept && !bus.i_flush) begin
        wb_valid_q <= 1'b1;
        wb_we_q    <= w_we;
        wb_rd_q    <= bus.i_ma_rd;
        wb_data_q  <= w_data;
      end else begin
        // rd/data intentionally hold their last values
        wb_valid_q <= 1'b0;
        wb_we_q    <= 1'b0;
      end
    end
  end

  assign bus.o_ma_ready   = w_ready;
  assign bus.o_wb_valid   = wb_valid_q;
  assign bus.o_wb_we      = wb_we_q;
  assign bus.o_wb_rd      = wb_rd_q;
  assign bus.o_wb_data    = wb_data_q;
  assign bus.o_retire_cnt = retire_cnt_q;
  assign bus.o_stall_cnt  = stall_cnt_q;
  assign bus.o_busy       = (state_q == ST_WAIT);

endmodule : wb_stage
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_stage
//  Description : Self-checking bench for wb_stage: vector table for load
//                extraction and source select, directed multi-cycle
//                sequences (stall, flush, back-to-back, reset mid-wait) and
//                a randomized run against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_stage_if #(.XLEN(32), .REG_AW(5), .CNT_W(64)) bus ();

  wb_stage #(.XLEN(32), .REG_AW(5), .CNT_W(64)) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [1:0]  rw_sel;
    logic        m2r;
    logic [2:0]  f3;
    logic [31:0] result;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        regw;
    logic [31:0] exp_data;
    logic        exp_we;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_ma_valid      = 1'b0;
    bus.i_ma_mem_to_reg = 1'b0;
    bus.i_ma_rw_sel     = 2'b00;
    bus.i_ma_funct3     = 3'b010;
    bus.i_ma_rd         = 5'd0;
    bus.i_ma_reg_write  = 1'b0;
    bus.i_ma_result     = 32'h0;
    bus.i_ma_pc_plus_4  = 32'h0;
    bus.i_ma_imm        = 32'h0;
    bus.i_mem_rdata     = 32'h0;
    bus.i_mem_rvalid    = 1'b0;
    bus.i_flush         = 1'b0;
  endtask

  task automatic present_lw(input logic [4:0] rd, input logic rvalid);
    bus.i_ma_valid      = 1'b1;
    bus.i_ma_mem_to_reg = 1'b1;
    bus.i_ma_rw_sel     = 2'b00;
    bus.i_ma_funct3     = 3'b010;
    bus.i_ma_rd         = rd;
    bus.i_ma_reg_write  = 1'b1;
    bus.i_ma_result     = 32'h0000_2000;
    bus.i_mem_rdata     = 32'hDEAD_BEEF;
    bus.i_mem_rvalid    = rvalid;
    bus.i_flush         = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"},  64'(bus.o_wb_valid), 64'd0);
    check({tag, "_we"},     64'(bus.o_wb_we), 64'd0);
    check({tag, "_rd"},     64'(bus.o_wb_rd), 64'd0);
    check({tag, "_data"},   64'(bus.o_wb_data), 64'd0);
    check({tag, "_retire"}, bus.o_retire_cnt, 64'd0);
    check({tag, "_stall"},  bus.o_stall_cnt, 64'd0);
    check({tag, "_busy"},   64'(bus.o_busy), 64'd0);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    check_reset_state("reset");
    rst = 1'b0;
  endtask

  // Reference load value from the extraction rules, using plain arithmetic
  function automatic logic [31:0] ref_load(input logic [31:0] rdata,
                                           input logic [1:0] off,
                                           input logic [2:0] f3);
    longint unsigned w = longint'(rdata);
    longint v;
    case (f3)
      3'b000, 3'b100: begin
        v = longint'((w / (64'd1 << (8 * off))) % 256);
        if (f3 == 3'b000 && v >= 128) v = v - 256;
      end
      3'b001, 3'b101: begin
        v = longint'((w / (64'd1 << (16 * (off / 2)))) % 65536);
        if (f3 == 3'b001 && v >= 32768) v = v - 65536;
      end
      default: v = longint'(w);
    endcase
    return v[31:0];
  endfunction

  // Model state for the randomized run
  logic        m_valid, m_we, m_busy;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  longint unsigned m_retire, m_stall;

  initial begin
    // ---------------- vector table ----------------
    //          sel    m2r   f3      result        pc4           imm           rdata         rd    rw    exp_data      we
    vecs[0]  = '{2'b00, 1'b1, 3'b000, 32'h0000_1001, 32'h0,        32'h0,        32'h8899AABB, 5'd5, 1'b1, 32'hFFFFFFAA, 1'b1};
    vecs[1]  = '{2'b00, 1'b1, 3'b100, 32'h0000_1001, 32'h0,        32'h0,        32'h8899AABB, 5'd6, 1'b1, 32'h000000AA, 1'b1};
    vecs[2]  = '{2'b00, 1'b1, 3'b001, 32'h0000_1002, 32'h0,        32'h0,        32'h8899AABB, 5'd7, 1'b1, 32'hFFFF8899, 1'b1};
    vecs[3]  = '{2'b00, 1'b1, 3'b101, 32'h0000_1002, 32'h0,        32'h0,        32'h8899AABB, 5'd8, 1'b1, 32'h00008899, 1'b1};
    vecs[4]  = '{2'b00, 1'b1, 3'b010, 32'h0000_1000, 32'h0,        32'h0,        32'h8899AABB, 5'd9, 1'b1, 32'h8899AABB, 1'b1};
    vecs[5]  = '{2'b00, 1'b1, 3'b000, 32'h0000_1000, 32'h0,        32'h0,        32'h8899AABB, 5'd10,1'b1, 32'hFFFFFFBB, 1'b1};
    vecs[6]  = '{2'b00, 1'b0, 3'b010, 32'hAAAAAAAA, 32'hCCCCCCCC, 32'h12345000, 32'h0,        5'd11,1'b1, 32'hAAAAAAAA, 1'b1};
    vecs[7]  = '{2'b01, 1'b0, 3'b010, 32'hAAAAAAAA, 32'hCCCCCCCC, 32'h12345000, 32'h0,        5'd12,1'b1, 32'hCCCCCCCC, 1'b1};
    vecs[8]  = '{2'b10, 1'b0, 3'b010, 32'hAAAAAAAA, 32'hCCCCCCCC, 32'h12345000, 32'h0,        5'd13,1'b0, 32'h12345000, 1'b0};
    vecs[9]  = '{2'b11, 1'b1, 3'b010, 32'hAAAAAAAA, 32'hCCCCCCCC, 32'h12345000, 32'h0,        5'd14,1'b1, 32'h00000000, 1'b1};
    vecs[10] = '{2'b01, 1'b0, 3'b010, 32'hAAAAAAAA, 32'hCCCCCCCC, 32'h12345000, 32'h0,        5'd0, 1'b1, 32'hCCCCCCCC, 1'b0};

    idle_inputs();
    do_reset();

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 11; i++) begin
      bus.i_ma_valid      = 1'b1;
      bus.i_ma_rw_sel     = vecs[i].rw_sel;
      bus.i_ma_mem_to_reg = vecs[i].m2r;
      bus.i_ma_funct3     = vecs[i].f3;
      bus.i_ma_result     = vecs[i].result;
      bus.i_ma_pc_plus_4  = vecs[i].pc4;
      bus.i_ma_imm        = vecs[i].imm;
      bus.i_mem_rdata     = vecs[i].rdata;
      bus.i_ma_rd         = vecs[i].rd;
      bus.i_ma_reg_write  = vecs[i].regw;
      bus.i_mem_rvalid    = 1'b1;
      #1;
      check($sformatf("vec%0d_ready", i), 64'(bus.o_ma_ready), 64'd1);
      tick();
      check($sformatf("vec%0d_valid", i), 64'(bus.o_wb_valid), 64'd1);
      check($sformatf("vec%0d_data", i),  64'(bus.o_wb_data), 64'(vecs[i].exp_data));
      check($sformatf("vec%0d_we", i),    64'(bus.o_wb_we), 64'(vecs[i].exp_we));
      check($sformatf("vec%0d_rd", i),    64'(bus.o_wb_rd), 64'(vecs[i].rd));
    end
    idle_inputs();
    tick();
    check("vec_idle_valid", 64'(bus.o_wb_valid), 64'd0);
    check("vec_idle_data_hold", 64'(bus.o_wb_data), 64'hCCCCCCCC);
    check("vec_retire", bus.o_retire_cnt, 64'd11);

    // ---------------- load stall of 3 cycles ----------------
    do_reset();
    for (int c = 0; c < 3; c++) begin
      present_lw(5'd3, 1'b0);
      #1;
      check($sformatf("stall%0d_ready", c), 64'(bus.o_ma_ready), 64'd0);
      tick();
      check($sformatf("stall%0d_busy", c),  64'(bus.o_busy), 64'd1);
      check($sformatf("stall%0d_valid", c), 64'(bus.o_wb_valid), 64'd0);
    end
    present_lw(5'd3, 1'b1);
    #1;
    check("stall_rv_ready", 64'(bus.o_ma_ready), 64'd1);
    tick();
    check("stall_wb_valid", 64'(bus.o_wb_valid), 64'd1);
    check("stall_wb_data",  64'(bus.o_wb_data), 64'hDEADBEEF);
    check("stall_busy_off", 64'(bus.o_busy), 64'd0);
    check("stall_cnt",      bus.o_stall_cnt, 64'd3);
    idle_inputs();
    tick();
    check("stall_pulse_end", 64'(bus.o_wb_valid), 64'd0);
    check("stall_retire",    bus.o_retire_cnt, 64'd1);

    // ---------------- back-to-back non-loads ----------------
    do_reset();
    for (int k = 0; k < 8; k++) begin
      idle_inputs();
      bus.i_ma_valid     = 1'b1;
      bus.i_ma_rw_sel    = 2'b10;
      bus.i_ma_imm       = 32'h1000 * (k + 1);
      bus.i_ma_rd        = 5'(k + 1);
      bus.i_ma_reg_write = 1'b1;
      tick();
      check($sformatf("b2b%0d_valid", k), 64'(bus.o_wb_valid), 64'd1);
      check($sformatf("b2b%0d_data", k),  64'(bus.o_wb_data), 64'(32'h1000 * (k + 1)));
    end
    idle_inputs();
    tick();
    check("b2b_retire", bus.o_retire_cnt, 64'd8);

    // ---------------- flush during WAIT_LOAD ----------------
    present_lw(5'd4, 1'b0);
    tick();
    present_lw(5'd4, 1'b0);
    tick();
    check("flush_pre_busy", 64'(bus.o_busy), 64'd1);
    present_lw(5'd4, 1'b0);
    bus.i_flush = 1'b1;
    #1;
    check("flush_ready", 64'(bus.o_ma_ready), 64'd1);
    tick();
    check("flush_valid",  64'(bus.o_wb_valid), 64'd0);
    check("flush_busy",   64'(bus.o_busy), 64'd0);
    check("flush_retire", bus.o_retire_cnt, 64'd8);
    idle_inputs();
    tick();
    check("flush_retire2", bus.o_retire_cnt, 64'd8);
    check("flush_stall",   bus.o_stall_cnt, 64'd2);

    // ---------------- reset in WAIT_LOAD ----------------
    present_lw(5'd2, 1'b0);
    tick();
    check("rstw_busy", 64'(bus.o_busy), 64'd1);
    rst = 1'b1;
    tick();
    check_reset_state("rstw");
    rst = 1'b0;
    idle_inputs();
    tick();
    check("rstw_after_busy", 64'(bus.o_busy), 64'd0);

    // ---------------- randomized run vs model ----------------
    do_reset();
    m_valid = 1'b0; m_we = 1'b0; m_busy = 1'b0; m_rd = '0; m_data = '0;
    m_retire = 0; m_stall = 0;
    for (int n = 0; n < 600; n++) begin
      logic pend, exp_ready, acc;
      logic [31:0] sel_val;
      bus.i_ma_valid      = ($urandom_range(0, 3) != 0);
      bus.i_ma_mem_to_reg = $urandom_range(0, 1) == 1;
      bus.i_ma_rw_sel     = ($urandom_range(0, 1) == 1) ? 2'b00 : 2'($urandom_range(0, 3));
      bus.i_ma_funct3     = 3'($urandom_range(0, 7));
      bus.i_ma_rd         = 5'($urandom_range(0, 31));
      bus.i_ma_reg_write  = $urandom_range(0, 1) == 1;
      bus.i_ma_result     = $urandom;
      bus.i_ma_pc_plus_4  = $urandom;
      bus.i_ma_imm        = $urandom;
      bus.i_mem_rdata     = $urandom;
      bus.i_mem_rvalid    = ($urandom_range(0, 2) == 0);
      bus.i_flush         = ($urandom_range(0, 15) == 0);
      #1;
      pend = bus.i_ma_valid && bus.i_ma_mem_to_reg && (bus.i_ma_rw_sel == 2'b00);
      exp_ready = bus.i_flush || !(pend && !bus.i_mem_rvalid);
      acc = bus.i_ma_valid && exp_ready;
      check($sformatf("rnd%0d_ready", n), 64'(bus.o_ma_ready), 64'(exp_ready));

      if (bus.i_ma_rw_sel == 2'b01)      sel_val = bus.i_ma_pc_plus_4;
      else if (bus.i_ma_rw_sel == 2'b10) sel_val = bus.i_ma_imm;
      else if (bus.i_ma_rw_sel == 2'b11) sel_val = 32'h0;
      else if (bus.i_ma_mem_to_reg)      sel_val = ref_load(bus.i_mem_rdata, bus.i_ma_result[1:0], bus.i_ma_funct3);
      else                               sel_val = bus.i_ma_result;

      m_retire = m_retire + (m_valid ? 1 : 0);
      if (bus.i_ma_valid && !exp_ready) m_stall = m_stall + 1;
      if (m_busy) m_busy = !(bus.i_mem_rvalid || bus.i_flush);
      else        m_busy = pend && !bus.i_mem_rvalid && !bus.i_flush;
      if (acc && !bus.i_flush) begin
        m_valid = 1'b1;
        m_we    = bus.i_ma_reg_write && (bus.i_ma_rd != 0);
        m_rd    = bus.i_ma_rd;
        m_data  = sel_val;
      end else begin
        m_valid = 1'b0;
        m_we    = 1'b0;
      end

      @(posedge clk);
      #1;
      check($sformatf("rnd%0d_valid", n),  64'(bus.o_wb_valid), 64'(m_valid));
      check($sformatf("rnd%0d_we", n),     64'(bus.o_wb_we), 64'(m_we));
      check($sformatf("rnd%0d_rd", n),     64'(bus.o_wb_rd), 64'(m_rd));
      check($sformatf("rnd%0d_data", n),   64'(bus.o_wb_data), 64'(m_data));
      check($sformatf("rnd%0d_busy", n),   64'(bus.o_busy), 64'(m_busy));
      check($sformatf("rnd%0d_retire", n), bus.o_retire_cnt, 64'(m_retire));
      check($sformatf("rnd%0d_stall", n),  bus.o_stall_cnt, 64'(m_stall));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_wb_stage
`default_nettype wire
